mdz_triplet_loader: RTL

MDZ_TRIPLET_LOADER -- requirements
Module: mdz_triplet_loader

---
 rtl/mdz_triplet_loader.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdz_triplet_loader.sv
// -----------------------------------------------------------------------------
// mdz_triplet_loader
//
// Collects a 7-word packet (header + six operands) from an inbound
// valid/ready word stream, presents the command bits and operands to an
// attached triplet merge stage, waits MERGE_LATENCY+1 cycles for that stage,
// then captures its result and offers it on an outbound valid/ready port.
//
// Header word: bit0 = merge, bit1 = which, bits[31:2] reserved.
//
// Optional feature (compile-time macro):
//   MDZ_TRIPLET_LOADER_HDR_CHECK_EN
//     When defined, a header with nonzero reserved bits sets the sticky err
//     flag; the six operands of that packet are still consumed, but no merge
//     is run and no result is offered. When undefined, err is tied low and
//     the reserved bits are ignored.
//
// Parameters:
//   MERGE_LATENCY  register latency of the merge stage, 0 or 1.
//
// Ports:
//   clk             clock, all state updates on its rising edge
//   rst_n           synchronous active-low reset
//   s_valid/s_ready inbound word handshake
//   s_data[31:0]    inbound word (header or operand)
//   merge, which    command bits to the merge stage
//   ai..fi[31:0]    operands to the merge stage
//   q[31:0], equal  result and triplet-equality from the merge stage
//   m_valid/m_ready outbound result handshake
//   m_data, m_equal captured q and equal
//   err             sticky reserved-header error flag
// -----------------------------------------------------------------------------
module mdz_triplet_loader #(
  parameter int MERGE_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        merge,
  output logic        which,
  output logic [31:0] ai,
  output logic [31:0] bi,
  output logic [31:0] ci,
  output logic [31:0] di,
  output logic [31:0] ei,
  output logic [31:0] fi,
  input  logic [31:0] q,
  input  logic        equal,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_equal,
  output logic        err
);

  // Reject unsupported merge latencies while elaborating.
  generate
    if (MERGE_LATENCY != 0 && MERGE_LATENCY != 1) begin : g_bad_latency
      $fatal(1, "Unsupported MERGE_LATENCY.");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_OPS  = 2'd1,
    ST_EXEC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Value of the EXEC cycle counter on the final EXEC cycle.
  localparam logic EXEC_LAST_CNT = (MERGE_LATENCY == 1) ? 1'b1 : 1'b0;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  idx_r;
  logic        exec_cnt_r;
  logic        exec_last_s;
  logic        merge_r;
  logic        which_r;
  logic [31:0] op_r [6];
  logic [31:0] m_data_r;
  logic        m_equal_r;
  logic        hdr_bad_r;
  logic        hdr_bad_s;
  logic        in_rdy_s;
  logic        accept_s;

`ifdef MDZ_TRIPLET_LOADER_HDR_CHECK_EN
  logic        err_r;
  assign hdr_bad_s = |s_data[31:2];
  assign err       = err_r;
`else
  assign hdr_bad_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Reset forces s_ready low even before the first reset edge is seen.
  assign s_ready     = in_rdy_s & rst_n;
  assign accept_s    = s_valid & s_ready;
  assign exec_last_s = (exec_cnt_r == EXEC_LAST_CNT);

  assign merge   = merge_r;
  assign which   = which_r;
  assign ai      = op_r[0];
  assign bi      = op_r[1];
  assign ci      = op_r[2];
  assign di      = op_r[3];
  assign ei      = op_r[4];
  assign fi      = op_r[5];
  assign m_valid = (state_r == ST_OUT);
  assign m_data  = m_data_r;
  assign m_equal = m_equal_r;

  // Next-state and inbound-ready decode.
  always_comb begin
    state_nxt_s = state_r;
    in_rdy_s    = 1'b0;
    case (state_r)
      ST_HDR: begin
        in_rdy_s = 1'b1;
        if (s_valid) begin
          state_nxt_s = ST_OPS;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_OPS: begin
        in_rdy_s = 1'b1;
        if (s_valid && (idx_r == 3'd5)) begin
          // A rejected header drains its operands but skips the merge.
          if (hdr_bad_r) begin
            state_nxt_s = ST_HDR;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end else begin
          state_nxt_s = ST_OPS;
        end
      end
      ST_EXEC: begin
        if (exec_last_s) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_HDR;
      end
    endcase
  end

  // State, packet capture and result capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_HDR;
      idx_r      <= 3'd0;
      exec_cnt_r <= 1'b0;
      merge_r    <= 1'b0;
      which_r    <= 1'b0;
      hdr_bad_r  <= 1'b0;
      m_data_r   <= 32'd0;
      m_equal_r  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        op_r[i] <= 32'd0;
      end
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_HDR: begin
          if (accept_s) begin
            merge_r   <= s_data[0];
            which_r   <= s_data[1];
            hdr_bad_r <= hdr_bad_s;
            idx_r     <= 3'd0;
          end
        end
        ST_OPS: begin
          if (accept_s) begin
            case (idx_r)
              3'd0:    op_r[0] <= s_data;
              3'd1:    op_r[1] <= s_data;
              3'd2:    op_r[2] <= s_data;
              3'd3:    op_r[3] <= s_data;
              3'd4:    op_r[4] <= s_data;
              3'd5:    op_r[5] <= s_data;
              default: ;
            endcase
            idx_r      <= idx_r + 3'd1;
            exec_cnt_r <= 1'b0;
          end
        end
        ST_EXEC: begin
          exec_cnt_r <= exec_cnt_r + 1'b1;
          // The merge stage output is valid on the final EXEC cycle.
          if (exec_last_s) begin
            m_data_r  <= q;
            m_equal_r <= equal;
          end
        end
        ST_OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MDZ_TRIPLET_LOADER_HDR_CHECK_EN
  // Sticky flag for headers carrying nonzero reserved bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_HDR) && accept_s && hdr_bad_s) begin
      err_r <= 1'b1;
    end
  end
`endif

endmodule
